iteration_vector_counter: RTL

Multi-dimensional loop counter for the Global Controller. It produces the iteration vector that feeds `mux_ivar_select` and, through it, the comparators in `minmax_comparator_matrix`. On `start` it latches per-dimension bounds and walks the iteration space in lexicographic order, one vector per accepted `step`. It reports per-dimension wrap events, the final vector (`last`) and completion (`done`).

---
 rtl/gc_pkg.sv | 19 +
 rtl/iteration_digit.sv | 47 ++++
 rtl/iteration_vector_counter.sv | 118 +++++++++++
 3 files changed

// File: rtl/gc_pkg.sv
// Shared Global Controller definitions: FSM encoding, default widths and vector packing.
// Packed vectors hold dimension x at [x*W +: W], dimension 0 in the leftmost bits.
package gc_pkg;

    localparam int unsigned DefaultIvarWidth = 16;
    localparam int unsigned DefaultDimension = 3;

    typedef logic [1:0] gc_state_t;

    localparam gc_state_t StIdle  = 2'd0;
    localparam gc_state_t StRun   = 2'd1;
    localparam gc_state_t StFlush = 2'd2;

    // Bit offset of dimension `dim` inside a packed iteration vector.
    function automatic int unsigned ivar_offset(input int unsigned dim, input int unsigned width);
        return dim * width;
    endfunction

endpackage

// File: rtl/iteration_digit.sv
// One dimension of the iteration counter: value register, bound compare, carry and wrap pulse.
// Carry ripples from the innermost digit outward; a digit at its bound reloads and passes it on.
module iteration_digit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] lower,
    input  logic [WIDTH-1:0] upper,
    input  logic             carry_in,
    output logic [WIDTH-1:0] value,
    output logic             at_bound,
    output logic             carry_out,
    output logic             wrap
);

    logic [WIDTH-1:0] value_q;
    logic             wrap_q;

    assign at_bound  = (value_q == upper);
    assign carry_out = carry_in & at_bound;
    assign value     = value_q;
    assign wrap      = wrap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (load) begin
                value_q <= load_value;
            end else if (carry_in) begin
                if (at_bound) begin
                    value_q <= lower;
                    wrap_q  <= 1'b1;
                end else begin
                    // Only reached below the bound, so this cannot overflow.
                    value_q <= value_q + {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end
    end

endmodule

// File: rtl/iteration_vector_counter.sv
// Multi-dimensional lexicographic loop counter; dimension DIMENSION-1 is innermost.
// Optional macro ITERATION_VECTOR_LOWER_BOUND_EN adds a latched lower_bounds port.
module iteration_vector_counter
    import gc_pkg::*;
#(
    parameter int unsigned ITERATION_VARIABLE_WIDTH = DefaultIvarWidth,
    parameter int unsigned DIMENSION                = DefaultDimension
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic                                          step,
    input  logic [0:DIMENSION*ITERATION_VARIABLE_WIDTH-1] upper_bounds,
`ifdef ITERATION_VECTOR_LOWER_BOUND_EN
    input  logic [0:DIMENSION*ITERATION_VARIABLE_WIDTH-1] lower_bounds,
`endif
    output logic [0:DIMENSION*ITERATION_VARIABLE_WIDTH-1] ivar_out,
    output logic                                          valid,
    output logic                                          last,
    output logic [DIMENSION-1:0]                          wrap,
    output logic                                          busy,
    output logic                                          done
);

    localparam int unsigned W = ITERATION_VARIABLE_WIDTH;
    localparam int unsigned D = DIMENSION;

    gc_state_t      state_q, state_d;
    logic [0:D*W-1] upper_q;
    logic [0:D*W-1] lower_q;
    logic [0:D*W-1] lower_in;
    logic [D-1:0]   at_bound;
    logic [D:0]     carry;
    logic           all_at_bound;
    logic           empty;
    logic           load_bounds;
    logic           load_ivar;
    logic           advance;
    logic           unused_carry;

`ifdef ITERATION_VECTOR_LOWER_BOUND_EN
    assign lower_in = lower_bounds;

    always_ff @(posedge clk) begin
        if (rst) begin
            lower_q <= '0;
        end else if (load_bounds) begin
            lower_q <= lower_bounds;
        end
    end
`else
    assign lower_in = '0;
    assign lower_q  = '0;
`endif

    always_comb begin
        empty = 1'b0;
        for (int unsigned x = 0; x < D; x++) begin
            if ($signed(upper_bounds[ivar_offset(x, W) +: W]) <
                $signed(lower_in[ivar_offset(x, W) +: W])) begin
                empty = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = empty ? StFlush : StRun;
            StRun:   if (step && all_at_bound) state_d = StFlush;
            StFlush: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            upper_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_bounds) begin
                upper_q <= upper_bounds;
            end
        end
    end

    assign all_at_bound = &at_bound;
    assign valid        = (state_q == StRun);
    assign busy         = valid;
    assign done         = (state_q == StFlush);
    assign last         = valid & all_at_bound;
    assign load_bounds  = (state_q == StIdle) & start;
    assign load_ivar    = load_bounds & ~empty;
    // The final step must not wrap anything: ivar_out holds the last vector.
    assign advance      = valid & step & ~all_at_bound;
    assign carry[D]     = advance;
    assign unused_carry = carry[0];

    for (genvar x = 0; x < D; x++) begin : g_digit
        iteration_digit #(
            .WIDTH(W)
        ) u_digit (
            .clk       (clk),
            .rst       (rst),
            .load      (load_ivar),
            .load_value(lower_in[x*W +: W]),
            .lower     (lower_q[x*W +: W]),
            .upper     (upper_q[x*W +: W]),
            .carry_in  (carry[x+1]),
            .value     (ivar_out[x*W +: W]),
            .at_bound  (at_bound[x]),
            .carry_out (carry[x]),
            .wrap      (wrap[D-1-x])
        );
    end

endmodule
